// File: rtl/bus_mem_ctrl.sv
// Downstream bus stage for cpu6502: commits CPU stores into mirrored RAM, hosts a
// memory-mapped byte-output FIFO, and drives the registered CPU read-data bus.
module bus_mem_ctrl #(
    parameter int unsigned RAM_AW  = 11,
    parameter logic [15:0] IO_BASE = 16'h4000,
    parameter int unsigned FIFO_AW = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] addr,
    input  logic [7:0]  odata,
    input  logic        rw,
    input  logic        clk2,
    input  logic [7:0]  rom_data,
    output logic [7:0]  idata,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        overflow
);
    localparam int unsigned RAM_DEPTH = 1 << RAM_AW;
    localparam int unsigned DEPTH     = 1 << FIFO_AW;
    localparam int unsigned CW        = FIFO_AW + 1;
    localparam logic [15:0] STAT_ADDR = IO_BASE + 16'd1;

    logic [7:0]         ram      [RAM_DEPTH];
    logic [7:0]         fifo_mem [DEPTH];
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW-1:0] wr_ptr;
    logic [CW-1:0]      count;
    logic [CW-1:0]      count_nxt;
    logic               clk2_q;

    logic [RAM_AW-1:0]  ram_idx;
    logic               is_ram;
    logic               is_out;
    logic               is_stat;
    logic               wr_stb;
    logic               full;
    logic               empty;
    logic               pop;
    logic               push;
    logic               push_ok;
    logic               drop;
    logic               ovf_clr;
    logic [3:0]         cnt_field;
    logic [7:0]         rd_data;

    // Address decode: RAM mirrors across the low 8 KiB, then the two I/O registers.
    always_comb begin
        ram_idx = addr[RAM_AW-1:0];
        is_ram  = (addr[15:13] == 3'b000);
        is_out  = !is_ram && (addr == IO_BASE);
        is_stat = !is_ram && (addr == STAT_ADDR);
    end

    // One store strobe on the first clk of each phi2 high phase.
    assign wr_stb = clk2 & ~clk2_q & ~rw;

    always_comb begin
        full      = (count == CW'(DEPTH));
        empty     = (count == '0);
        pop       = out_valid & out_ready;
        push      = wr_stb & is_out;
        push_ok   = push & (~full | pop);
        drop      = push & full & ~pop;
        ovf_clr   = wr_stb & is_stat & odata[2];
        count_nxt = count;
        case ({push_ok, pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    // Read mux; the STAT count field saturates so deep FIFOs still fit in 4 bits.
    always_comb begin
        cnt_field = 4'(count);
        if (32'(count) > 32'd15) begin
            cnt_field = 4'hF;
        end
        rd_data = rom_data;
        if (is_ram) begin
            rd_data = ram[ram_idx];
        end else if (is_out) begin
            rd_data = 8'h00;
        end else if (is_stat) begin
            rd_data = {cnt_field, 1'b0, overflow, empty, full};
        end
    end

    always_ff @(posedge clk) begin
        if (wr_stb && is_ram) begin
            ram[ram_idx] <= odata;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= odata;
        end
    end

    // clk2_q resets high so a phi2 already high at reset release does not store.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk2_q    <= 1'b1;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
            idata     <= 8'h00;
        end else begin
            clk2_q    <= clk2;
            idata     <= rd_data;
            count     <= count_nxt;
            out_valid <= (count_nxt != '0);
            if (push_ok) begin
                wr_ptr <= wr_ptr + FIFO_AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + FIFO_AW'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    assign out_data = fifo_mem[rd_ptr];

endmodule

// File: tb/tb_bus_mem_ctrl.sv
// Bench for bus_mem_ctrl: table vectors, directed FIFO/overflow/reset sequences and
// randomized bus traffic checked against a queue-based reference model.
module tb_bus_mem_ctrl;
    logic        clk;
    logic        reset;
    logic [15:0] addr;
    logic [7:0]  odata;
    logic        rw;
    logic        clk2;
    logic [7:0]  rom_data;
    logic [7:0]  idata;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        overflow;

    bus_mem_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .addr      (addr),
        .odata     (odata),
        .rw        (rw),
        .clk2      (clk2),
        .rom_data  (rom_data),
        .idata     (idata),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;

    // Reference model state
    logic [7:0] m_ram  [2048];
    bit         m_ramv [2048];
    logic [7:0] q [$];
    logic       m_ovf;
    logic       m_c2;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
        logic        r;
        logic        c2;
        logic        rdy;
        logic        chk;
        logic [7:0]  exp_idata;
        logic        exp_valid;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc_n, act, exp);
        end
    endtask

    function automatic logic [7:0] stat_byte();
        int n;
        logic [3:0] c;
        n = q.size();
        c = (n > 15) ? 4'hF : 4'(n);
        return {c, 1'b0, m_ovf, (n == 0), (n == 8)};
    endfunction

    // One clk: drive inputs, advance, update model, compare outputs.
    task automatic cyc(input logic [15:0] a, input logic [7:0] d, input logic r,
                       input logic c2, input logic rdy);
        logic [7:0] rom;
        logic [7:0] exp_idata;
        logic       known;
        rom = 8'($urandom);
        addr = a; odata = d; rw = r; clk2 = c2; out_ready = rdy; rom_data = rom;
        @(posedge clk);
        cyc_n++;
        known = 1'b1;
        if (a[15:13] == 3'b000) begin
            exp_idata = m_ram[a[10:0]];
            known     = m_ramv[a[10:0]];
        end else if (a == 16'h4000) begin
            exp_idata = 8'h00;
        end else if (a == 16'h4001) begin
            exp_idata = stat_byte();
        end else begin
            exp_idata = rom;
        end
        if (q.size() > 0 && rdy) void'(q.pop_front());
        if (c2 && !m_c2 && !r) begin
            if (a[15:13] == 3'b000) begin
                m_ram[a[10:0]]  = d;
                m_ramv[a[10:0]] = 1'b1;
            end else if (a == 16'h4000) begin
                if (q.size() < 8) q.push_back(d);
                else m_ovf = 1'b1;
            end else if (a == 16'h4001 && d[2]) begin
                m_ovf = 1'b0;
            end
        end
        m_c2 = c2;
        #1;
        if (known) check("model idata", 32'(idata), 32'(exp_idata));
        check("model out_valid", 32'(out_valid), 32'(q.size() != 0));
        if (q.size() != 0) check("model out_data", 32'(out_data), 32'(q[0]));
        check("model overflow", 32'(overflow), 32'(m_ovf));
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d, input logic rdy);
        cyc(a, d, 1'b0, 1'b0, rdy);
        cyc(a, d, 1'b0, 1'b1, rdy);
    endtask

    task automatic cpu_read(input logic [15:0] a);
        cyc(a, 8'h00, 1'b1, 1'b0, 1'b0);
    endtask

    // Asynchronous reset asserted away from the clock edge, held two clks.
    task automatic async_reset();
        #2;
        reset = 1'b0;
        #1;
        q.delete();
        m_ovf = 1'b0;
        m_c2  = 1'b1;
        check("reset idata", 32'(idata), 32'h00);
        check("reset out_valid", 32'(out_valid), 32'h0);
        check("reset overflow", 32'(overflow), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; addr = 16'h0; odata = 8'h0; rw = 1'b1; clk2 = 1'b0;
        out_ready = 1'b0; rom_data = 8'h0;
        m_ovf = 1'b0; m_c2 = 1'b1;
        #1;
        async_reset();

        // Single store across a long phi2 high phase, then mirrored reads.
        vecs[0] = '{16'h4001, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h02, 1'b0};
        vecs[1] = '{16'h0099, 8'hEF, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[2] = '{16'h0099, 8'hEF, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[3] = '{16'h0099, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'hEF, 1'b0};
        vecs[4] = '{16'h0099, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'hEF, 1'b0};
        vecs[5] = '{16'h0899, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'hEF, 1'b0};
        vecs[6] = '{16'h1899, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'hEF, 1'b0};
        vecs[7] = '{16'h2099, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[8] = '{16'h4000, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0};
        for (int i = 0; i < 9; i++) begin
            cyc(vecs[i].a, vecs[i].d, vecs[i].r, vecs[i].c2, vecs[i].rdy);
            if (vecs[i].chk) check("vec idata", 32'(idata), 32'(vecs[i].exp_idata));
            check("vec out_valid", 32'(out_valid), 32'(vecs[i].exp_valid));
        end

        // Fill, overflow, then drain in order.
        for (int i = 0; i < 8; i++) cpu_write(16'h4000, 8'h11 + 8'(i), 1'b0);
        cpu_read(16'h4001);
        check("stat full", 32'(idata), 32'h81);
        cpu_write(16'h4000, 8'h99, 1'b0);
        cpu_read(16'h4001);
        check("stat overflow", 32'(idata), 32'h85);
        check("overflow set", 32'(overflow), 32'h1);
        for (int i = 0; i < 8; i++) begin
            check("drain order", 32'(out_data), 32'h11 + 32'(i));
            cyc(16'h4001, 8'h00, 1'b1, 1'b0, 1'b1);
        end
        check("drained empty", 32'(out_valid), 32'h0);

        // Overflow clear only through bit 2 of a STAT write.
        cpu_write(16'h4001, 8'hFB, 1'b0);
        check("ovf kept", 32'(overflow), 32'h1);
        cpu_write(16'h4001, 8'h04, 1'b0);
        check("ovf cleared", 32'(overflow), 32'h0);
        cpu_write(16'h4001, 8'h00, 1'b0);
        check("ovf still clear", 32'(overflow), 32'h0);

        // Push into a full FIFO in the same clk as a pop.
        for (int i = 0; i < 8; i++) cpu_write(16'h4000, 8'h11 + 8'(i), 1'b0);
        cyc(16'h4000, 8'hAA, 1'b0, 1'b0, 1'b0);
        cyc(16'h4000, 8'hAA, 1'b0, 1'b1, 1'b1);
        check("push+pop head", 32'(out_data), 32'h12);
        check("push+pop ovf", 32'(overflow), 32'h0);
        cpu_read(16'h4001);
        check("push+pop stat", 32'(idata), 32'h81);
        for (int i = 0; i < 8; i++) begin
            check("drain2 order", 32'(out_data), (i == 7) ? 32'hAA : 32'h12 + 32'(i));
            cyc(16'h0099, 8'h00, 1'b1, 1'b0, 1'b1);
        end
        check("drain2 empty", 32'(out_valid), 32'h0);

        // Reset mid-run with bytes queued; RAM survives, phi2 high at release is not a store.
        for (int i = 0; i < 3; i++) cpu_write(16'h4000, 8'hA1 + 8'(i), 1'b0);
        cpu_read(16'h0099);
        check("pre-reset idata", 32'(idata), 32'hEF);
        async_reset();
        cyc(16'h0099, 8'h55, 1'b0, 1'b1, 1'b0);
        cpu_read(16'h0099);
        check("ram retained", 32'(idata), 32'hEF);
        cpu_read(16'h4001);
        check("stat after reset", 32'(idata), 32'h02);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] a;
            logic        c2;
            int          sel;
            sel = $urandom_range(0, 9);
            if (sel <= 3)      a = {3'b000, 2'($urandom), 7'b0, 4'($urandom)};
            else if (sel <= 5) a = 16'h4000;
            else if (sel == 6) a = 16'h4001;
            else               a = 16'($urandom);
            c2 = ($urandom_range(0, 2) != 0) ? ~clk2 : clk2;
            cyc(a, 8'($urandom), 1'($urandom), c2, ($urandom_range(0, 3) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
